// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 28;
    localparam int unsigned DEF_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // A requester is eligible only with exactly one of read/write raised.
    function automatic logic port_eligible(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-style handshake: read/write/addr/wdata out, rdata/ready back.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    // Side that issues requests.
    modport master (
        output read, write, addr, wdata,
        input  rdata, ready
    );

    // Side that services requests.
    modport slave (
        input  read, write, addr, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the port that did not win last goes.
module rr_arbiter2 (
    input  logic [1:0] elig_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

    // Combinational pick; the caller registers the result.
    always_comb begin
        grant_valid_o = |elig_i;
        grant_id_o    = 1'b0;
        if (&elig_i) begin
            grant_id_o = ~last_grant_i;
        end else begin
            grant_id_o = elig_i[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one handshake memory between two caches, one transaction at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   p0_if,
    mem_arbiter_if.slave   p1_if,
    mem_arbiter_if.master  mem_if
);

    state_e            state_q,      state_d;
    op_e               op_q,         op_d;
    logic              gid_q,        gid_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DATA_W-1:0] p0_rdata_q,   p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q,   p1_rdata_d;
    logic              p0_ready_q,   p0_ready_d;
    logic              p1_ready_q,   p1_ready_d;

    logic [1:0]        elig;
    logic              grant_valid;
    logic              grant_id;
    logic              grant_is_wr;

    assign elig = {port_eligible(p1_if.read, p1_if.write),
                   port_eligible(p0_if.read, p0_if.write)};

    rr_arbiter2 u_rr (
        .elig_i        (elig),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    assign grant_is_wr = grant_id ? p1_if.write : p0_if.write;

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        gid_d        = gid_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        p0_ready_d   = 1'b0;
        p1_ready_d   = 1'b0;

        unique case (state_q)
            // Wait out a stale mem_ready before any new grant.
            ST_DRAIN: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (!mem_if.ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (grant_valid) begin
                    gid_d        = grant_id;
                    last_grant_d = grant_id;
                    op_d         = grant_is_wr ? OP_WRITE : OP_READ;
                    mem_read_d   = ~grant_is_wr;
                    mem_write_d  = grant_is_wr;
                    mem_addr_d   = grant_id ? p1_if.addr  : p0_if.addr;
                    mem_wdata_d  = grant_id ? p1_if.wdata : p0_if.wdata;
                    state_d      = ST_BUSY;
                end
            end
            // Requester inputs are ignored here; memory outputs hold.
            ST_BUSY: begin
                if (mem_if.ready) begin
                    if (op_q == OP_READ) begin
                        if (gid_q) begin
                            p1_rdata_d = mem_if.rdata;
                        end else begin
                            p0_rdata_d = mem_if.rdata;
                        end
                    end
                    if (gid_q) begin
                        p1_ready_d = 1'b1;
                    end else begin
                        p0_ready_d = 1'b1;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DRAIN;
            end
            default: begin
                state_d = ST_DRAIN;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_DRAIN;
            op_q         <= OP_READ;
            gid_q        <= 1'b0;
            last_grant_q <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            p0_ready_q   <= 1'b0;
            p1_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            gid_q        <= gid_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            p0_ready_q   <= p0_ready_d;
            p1_ready_q   <= p1_ready_d;
        end
    end

    assign mem_if.read  = mem_read_q;
    assign mem_if.write = mem_write_q;
    assign mem_if.addr  = mem_addr_q;
    assign mem_if.wdata = mem_wdata_q;
    assign p0_if.rdata  = p0_rdata_q;
    assign p0_if.ready  = p0_ready_q;
    assign p1_if.rdata  = p1_rdata_q;
    assign p1_if.ready  = p1_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a stale-ready memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW  = DEF_ADDR_W;
    localparam int unsigned DW  = DEF_DATA_W;
    localparam int          LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .p0_if  (p0_if),
        .p1_if  (p1_if),
        .mem_if (mem_if)
    );

    int checks = 0;
    int errors = 0;

    // Memory model: ready rises LAT+1 edges after accept and stays up
    // until an idle request is seen (plus hold_cfg extra edges).
    logic [DW-1:0] mem_arr [0:31];
    logic [DW-1:0] m_rdata, m_wdata;
    logic          m_ready, m_busy, m_op_wr;
    logic [4:0]    m_addr;
    int            m_cnt, m_hold, hold_cfg;

    assign mem_if.rdata = m_rdata;
    assign mem_if.ready = m_ready;

    always @(posedge clk) begin
        if (m_busy) begin
            if (m_cnt == 0) begin
                if (m_op_wr) mem_arr[m_addr] <= m_wdata;
                else         m_rdata <= mem_arr[m_addr];
                m_ready <= 1'b1;
                m_hold  <= hold_cfg;
                m_busy  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (m_ready) begin
            if (!(mem_if.read || mem_if.write)) begin
                if (m_hold != 0) m_hold <= m_hold - 1;
                else             m_ready <= 1'b0;
            end
        end else if (mem_if.read || mem_if.write) begin
            m_busy  <= 1'b1;
            m_cnt   <= LAT;
            m_op_wr <= mem_if.write;
            m_addr  <= mem_if.addr[4:0];
            m_wdata <= mem_if.wdata;
        end
    end

    // Requester drivers (kind: 1 read, 2 write, 3 read+write) and monitors.
    int            p0_kind, p1_kind, p0_left, p1_left;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wd, p1_wd;
    int            rdy0_cnt, rdy1_cnt, overlap_cnt, rise_viol, fall_cnt;
    int            wr_cnt, rd_rise_cnt;
    int            log_q [$];
    logic          prev_req;

    always @(negedge clk) begin
        if (p0_if.ready) begin
            log_q.push_back(0);
            rdy0_cnt++;
            if (p0_left > 0) p0_left--;
            p0_if.read = 1'b0; p0_if.write = 1'b0;
        end else if (p0_left > 0) begin
            p0_if.read  = (p0_kind == 1) || (p0_kind == 3);
            p0_if.write = (p0_kind == 2) || (p0_kind == 3);
            p0_if.addr  = p0_addr;
            p0_if.wdata = p0_wd;
        end else begin
            p0_if.read = 1'b0; p0_if.write = 1'b0;
        end
        if (p1_if.ready) begin
            log_q.push_back(1);
            rdy1_cnt++;
            if (p1_left > 0) p1_left--;
            p1_if.read = 1'b0; p1_if.write = 1'b0;
        end else if (p1_left > 0) begin
            p1_if.read  = (p1_kind == 1) || (p1_kind == 3);
            p1_if.write = (p1_kind == 2) || (p1_kind == 3);
            p1_if.addr  = p1_addr;
            p1_if.wdata = p1_wd;
        end else begin
            p1_if.read = 1'b0; p1_if.write = 1'b0;
        end
        if (p0_if.ready && p1_if.ready) overlap_cnt++;
        if (mem_if.write) wr_cnt++;
        if (mem_if.read && !prev_req) rd_rise_cnt++;
        if ((mem_if.read || mem_if.write) && !prev_req && mem_if.ready) rise_viol++;
        if (!(mem_if.read || mem_if.write) && prev_req) fall_cnt++;
        prev_req = mem_if.read || mem_if.write;
    end

    task automatic wait_ports(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (p0_left == 0 && p1_left == 0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_if.read !== 1'b0 || mem_if.write !== 1'b0 || mem_if.addr !== '0 || mem_if.wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem_out got rd=%b wr=%b addr=%h expected all 0", mem_if.read, mem_if.write, mem_if.addr);
        end
        checks++;
        if (p0_if.ready !== 1'b0 || p1_if.ready !== 1'b0 || p0_if.rdata !== '0 || p1_if.rdata !== '0) begin
            errors++;
            $display("FAIL reset_port_out got r0=%b r1=%b expected ready/rdata 0", p0_if.ready, p1_if.ready);
        end
        checks++;
        if (dut.state_q !== ST_DRAIN) begin
            errors++;
            $display("FAIL reset_state got %0d expected %0d", dut.state_q, ST_DRAIN);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_to_idle got %0d expected %0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_single_read();
        int b0, b1;
        bit to;
        b0 = rdy0_cnt; b1 = rdy1_cnt;
        p0_kind = 1; p0_addr = 28'h10; p0_left = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_if.read !== 1'b1 || mem_if.write !== 1'b0 || mem_if.addr !== 28'h10) begin
            errors++;
            $display("FAIL single_issue got rd=%b wr=%b addr=%h expected 1 0 10", mem_if.read, mem_if.write, mem_if.addr);
        end
        wait_ports(50, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout got timeout expected completion"); end
        checks++;
        if (rdy0_cnt - b0 != 1 || rdy1_cnt - b1 != 0) begin
            errors++;
            $display("FAIL single_ready got p0=%0d p1=%0d expected 1 0", rdy0_cnt - b0, rdy1_cnt - b1);
        end
        checks++;
        if (p0_if.rdata !== 128'hC0DE0010_C0DE0010_C0DE0010_C0DE0010) begin
            errors++;
            $display("FAIL single_rdata got %h expected c0de0010 x4", p0_if.rdata);
        end
    endtask

    task automatic test_both_read();
        int ov, rv, fc;
        bit to;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        log_q.delete();
        ov = overlap_cnt; rv = rise_viol; fc = fall_cnt;
        p0_kind = 1; p0_addr = 28'h1; p0_left = 1;
        p1_kind = 1; p1_addr = 28'h2; p1_left = 1;
        wait_ports(80, to);
        checks++;
        if (to) begin errors++; $display("FAIL both_timeout got timeout expected completion"); end
        checks++;
        if (log_q.size() != 2) begin
            errors++;
            $display("FAIL both_count got %0d expected 2", log_q.size());
        end else begin
            checks++;
            if (log_q[0] != 0 || log_q[1] != 1) begin
                errors++;
                $display("FAIL both_order got %0d,%0d expected 0,1", log_q[0], log_q[1]);
            end
        end
        checks++;
        if (overlap_cnt != ov || rise_viol != rv || fall_cnt - fc != 2) begin
            errors++;
            $display("FAIL both_gap got ovl=%0d stale=%0d drops=%0d expected 0 0 2", overlap_cnt - ov, rise_viol - rv, fall_cnt - fc);
        end
        checks++;
        if (p0_if.rdata !== 128'hC0DE0001_C0DE0001_C0DE0001_C0DE0001 || p1_if.rdata !== 128'hC0DE0002_C0DE0002_C0DE0002_C0DE0002) begin
            errors++;
            $display("FAIL both_rdata got %h %h expected line1 line2", p0_if.rdata, p1_if.rdata);
        end
    endtask

    task automatic test_fairness();
        bit to;
        log_q.delete();
        p0_kind = 1; p0_addr = 28'h6; p0_left = 3;
        p1_kind = 1; p1_addr = 28'h7; p1_left = 3;
        wait_ports(200, to);
        checks++;
        if (to) begin errors++; $display("FAIL fair_timeout got timeout expected completion"); end
        checks++;
        if (log_q.size() != 6) begin
            errors++;
            $display("FAIL fair_count got %0d expected 6", log_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (log_q[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL fair_order idx %0d got %0d expected %0d", i, log_q[i], i % 2);
                end
            end
        end
        checks++;
        if (p1_if.rdata !== 128'hC0DE0007_C0DE0007_C0DE0007_C0DE0007) begin
            errors++;
            $display("FAIL fair_rdata got %h expected line7", p1_if.rdata);
        end
    endtask

    task automatic test_write_read();
        bit to;
        p1_kind = 2; p1_addr = 28'h5; p1_wd = {16{8'hA5}}; p1_left = 1;
        wait_ports(50, to);
        checks++;
        if (to || p1_if.rdata !== 128'hC0DE0007_C0DE0007_C0DE0007_C0DE0007) begin
            errors++;
            $display("FAIL write_keeps_rdata got %h to=%0d expected line7", p1_if.rdata, to);
        end
        p0_kind = 1; p0_addr = 28'h5; p0_left = 1;
        wait_ports(50, to);
        checks++;
        if (to || p0_if.rdata !== {16{8'hA5}}) begin
            errors++;
            $display("FAIL read_after_write got %h to=%0d expected a5 x16", p0_if.rdata, to);
        end
    endtask

    task automatic test_illegal();
        int b0, b1, w0, r0;
        bit to;
        b0 = rdy0_cnt; b1 = rdy1_cnt; w0 = wr_cnt; r0 = rd_rise_cnt;
        p0_kind = 3; p0_addr = 28'h4; p0_left = 1;
        p1_kind = 1; p1_addr = 28'h9; p1_left = 1;
        to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (p1_left == 0) begin to = 1'b0; break; end
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (to || rdy1_cnt - b1 != 1 || p1_if.rdata !== 128'hC0DE0009_C0DE0009_C0DE0009_C0DE0009) begin
            errors++;
            $display("FAIL illegal_p1 got rdy=%0d to=%0d rdata=%h expected 1 0 line9", rdy1_cnt - b1, to, p1_if.rdata);
        end
        checks++;
        if (rdy0_cnt != b0 || wr_cnt != w0 || rd_rise_cnt - r0 != 1) begin
            errors++;
            $display("FAIL illegal_p0 got rdy=%0d wr=%0d rd=%0d expected 0 0 1", rdy0_cnt - b0, wr_cnt - w0, rd_rise_cnt - r0);
        end
        p0_left = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_busy();
        int b0, viol, hi;
        bit to;
        b0 = rdy0_cnt; viol = 0; hi = 0;
        hold_cfg = 3;
        p0_kind = 1; p0_addr = 28'h3; p0_left = 1;
        to = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_if.ready) begin to = 1'b0; break; end
        end
        checks++;
        if (to || dut.state_q !== ST_BUSY) begin
            errors++;
            $display("FAIL rstbusy_setup got to=%0d state=%0d expected busy", to, dut.state_q);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (mem_if.read !== 1'b0 || p0_if.ready !== 1'b0 || p0_if.rdata !== '0) begin
            errors++;
            $display("FAIL rstbusy_abandon got rd=%b rdy=%b rdata=%h expected 0 0 0", mem_if.read, p0_if.ready, p0_if.rdata);
        end
        for (int i = 0; i < 20 && mem_if.ready; i++) begin
            @(negedge clk);
            if (mem_if.ready) begin
                hi++;
                if (mem_if.read || mem_if.write) viol++;
            end
        end
        checks++;
        if (viol != 0 || hi == 0) begin
            errors++;
            $display("FAIL rstbusy_drain got grants=%0d stale_cycles=%0d expected 0 >0", viol, hi);
        end
        wait_ports(60, to);
        hold_cfg = 0;
        checks++;
        if (to || rdy0_cnt - b0 != 1 || p0_if.rdata !== 128'hC0DE0003_C0DE0003_C0DE0003_C0DE0003) begin
            errors++;
            $display("FAIL rstbusy_retry got rdy=%0d to=%0d rdata=%h expected 1 0 line3", rdy0_cnt - b0, to, p0_if.rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_arr[i] = {4{32'hC0DE0000 + 32'(i)}};
        m_rdata = '0; m_wdata = '0; m_ready = 1'b0; m_busy = 1'b0; m_op_wr = 1'b0;
        m_addr = '0; m_cnt = 0; m_hold = 0; hold_cfg = 0;
        p0_kind = 0; p1_kind = 0; p0_left = 0; p1_left = 0;
        p0_addr = '0; p1_addr = '0; p0_wd = '0; p1_wd = '0;
        rdy0_cnt = 0; rdy1_cnt = 0; overlap_cnt = 0; rise_viol = 0; fall_cnt = 0;
        wr_cnt = 0; rd_rise_cnt = 0; prev_req = 1'b0;
        p0_if.read = 1'b0; p0_if.write = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
        p1_if.read = 1'b0; p1_if.write = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;

        test_reset();
        test_single_read();
        test_both_read();
        test_fairness();
        test_write_read();
        test_illegal();
        test_reset_busy();

        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL ready_overlap got %0d expected 0", overlap_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
